// File: rtl/somador_pkg.sv
// Shared definitions for the serial adder/subtractor: state encoding, derived
// sizes and the WIDTH/DIGIT legality rule.
package somador_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } estado_t;

   // Number of DIGIT-bit slices in a WIDTH-bit word (guarded against DIGIT=0).
   function automatic int unsigned calc_ndig(input int unsigned width,
                                             input int unsigned digit);
      return (digit == 0) ? 1 : width / digit;
   endfunction

   // Digit counter width, never narrower than one bit.
   function automatic int unsigned calc_cw(input int unsigned ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

   function automatic bit params_ok(input int unsigned width,
                                    input int unsigned digit);
      return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/somador_digito.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its
// most significant bit so the caller can derive signed overflow.
module somador_digito #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   always_comb begin
      logic cy;
      cy   = cin;
      cmsb = 1'b0;
      s    = '0;
      for (int i = 0; i < DIGIT; i++) begin
         cmsb = cy;
         s[i] = a[i] ^ b[i] ^ cy;
         cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      cout = cy;
   end

endmodule

// File: rtl/somador_serial.sv
// Multi-cycle adder/subtractor: processes one DIGIT-bit slice per clock, LSB
// first, through a single shared slice adder framed by start/busy/done.
module somador_serial
   import somador_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             ovf
);

   localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int unsigned CW   = calc_cw(NDIG);

   generate
      if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
         $fatal(1, "somador_serial: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   estado_t          state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] opa, opa_n;
   logic [WIDTH-1:0] opb, opb_n;
   logic [WIDTH-1:0] psum, psum_n, psum_sh;
   logic             carry, carry_n;
   logic [WIDTH-1:0] s_n;
   logic             cout_n, ovf_n, done_n;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co, dig_cm;

   somador_digito #(.DIGIT(DIGIT)) u_digito (
      .a    (opa[DIGIT-1:0]),
      .b    (opb[DIGIT-1:0]),
      .cin  (carry),
      .s    (dig_s),
      .cout (dig_co),
      .cmsb (dig_cm)
   );

   // New sum digit enters at the MSB end so the word is aligned after NDIG shifts.
   assign psum_sh = (psum >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         psum  <= '0;
         carry <= 1'b0;
         S     <= '0;
         Cout  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         opa   <= opa_n;
         opb   <= opb_n;
         psum  <= psum_n;
         carry <= carry_n;
         S     <= s_n;
         Cout  <= cout_n;
         ovf   <= ovf_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      opa_n   = opa;
      opb_n   = opb;
      psum_n  = psum;
      carry_n = carry;
      s_n     = S;
      cout_n  = Cout;
      ovf_n   = ovf;
      done_n  = 1'b0;

      case (state)
         IDLE: begin
            // Subtraction is A + ~B + ~borrow, so B and Cin are inverted on entry.
            if (start) begin
               opa_n   = A;
               opb_n   = B ^ {WIDTH{sub}};
               carry_n = Cin ^ sub;
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            opa_n   = opa >> DIGIT;
            opb_n   = opb >> DIGIT;
            carry_n = dig_co;
            psum_n  = psum_sh;
            cnt_n   = cnt + CW'(1);
            if (cnt == CW'(NDIG - 1)) begin
               s_n     = psum_sh;
               cout_n  = dig_co;
               ovf_n   = dig_co ^ dig_cm;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised multi-cycle adder/subtractor, the sequential successor to the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, LSB digit first. The whole operation reuses a single slice adder, and a start/busy/done handshake frames it. It sits beside the combinational adders in the arithmetic datapath and serves wide operands where area matters more than latency.

## Interface
- WIDTH, 16: operand and result width in bits.
- DIGIT, 4: bits processed per cycle. WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH are required. NDIG = WIDTH/DIGIT.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0: A+B+Cin; 1: A-B-Cin.
- A  in  WIDTH  operand A, unsigned or two's complement.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (sub=0) or borrow-in (sub=1).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, result valid.
- S  out  WIDTH  result.
- Cout  out  1  carry-out; when sub=1, 1 = no borrow.
- ovf  out  1  signed overflow.

## Operation
- States: IDLE, RUN. There is a digit counter of width max(1,$clog2(NDIG)).
- IDLE with start=1:
  - latch A, plus B XOR {WIDTH{sub}}, into operand shift registers.
  - set carry register to Cin XOR sub.
  - clear counter; go to RUN.
- RUN, each cycle:
  - the slice adds the low DIGIT bits of both operand registers plus the carry.
  - sum digit shifts into the MSB end of the partial-sum register; the operands shift right by DIGIT.
  - carry register takes the slice carry-out.
  - counter increments.
- Last digit (counter == NDIG-1):
  - S <= final sum; Cout <= slice carry-out.
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done <= 1; state goes to IDLE.
- S, Cout and ovf update only at completion. They hold their value until the next completion and never show partial results.
- start while busy=1 is ignored. Input values are don't-care except in the cycle start is accepted.
- Operands are latched, so A, B, sub and Cin may change freely after acceptance.
- NDIG == 1 degenerates to a registered single-cycle adder. The same handshake applies.

## Timing
- Reset values: state IDLE, busy 0, done 0, S 0, Cout 0, ovf 0. All internal registers are 0.
- Start accepted at edge t0 → busy=1 from t0 through edge tNDIG.
- At edge tNDIG: busy=0, done=1 for exactly one cycle, S/Cout/ovf valid. Latency is NDIG cycles from the accepting edge.
- Back-to-back: start=1 in the cycle where done=1 is accepted at the next edge. Throughput is one result per NDIG+1 cycles.
- rst_n low at any time, including mid-RUN: all outputs go to reset values immediately. The operation is aborted, no done is produced, and the block stays in IDLE after release.
- busy and done are never both 1.

## Structure
- Shared package somador_pkg holds:
  - the state encoding constants IDLE=1'b0, RUN=1'b1;
  - the function computing NDIG and the counter width;
  - the parameter-legality check, which is elaboration-time and stops elaboration on illegal WIDTH/DIGIT.
- Sub-module somador_digito #(DIGIT): combinational DIGIT-bit adder with cin/cout. It also exports carry-into-MSB so the top level can compute ovf. It is the generalised form of the 4-bit ripple adder.
- Top level: FSM, counter, shift registers, result registers.

## Test plan
- WIDTH=16, DIGIT=4, A=0x0002, B=0x0001, Cin=0, sub=0 → S=0x0003, Cout=0, ovf=0; done exactly 4 cycles after the accepting edge; busy high for 4 cycles.
- Same config, A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, ovf=0. Then A=0x7FFF, B=0x0001 → S=0x8000, Cout=0, ovf=1.
- Same config, sub=1, A=0x0005, B=0x0007, Cin=0 → S=0xFFFE, Cout=0 (borrow), ovf=0. Then A=0x8000, B=0x0001, Cin=0 → S=0x7FFF, Cout=1, ovf=1.
- Pulse start again during busy with different operands → ignored; the first result is unchanged. Then assert start in the done cycle → second operation accepted, done 4 cycles later.
- Drive rst_n low during the 2nd RUN cycle → busy, done, S, Cout and ovf are 0 immediately; no done after release. A new start then completes normally.
- WIDTH=4, DIGIT=1, A=4'b1010, B=4'b1110, Cin=1 → S=4'b1001, Cout=1, done after 4 cycles. WIDTH=16, DIGIT=16, A=0x0002, B=0x0006 → S=0x0008, done 1 cycle after accept.
